// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the pipeline-stage register and its future stage wrappers.
package pipe_stage_reg_pkg;

    localparam int unsigned PIPE_WIDTH = 32;

    // Fill state of the two-slot stage, decoded from {valid_s, valid_m}.
    typedef enum logic [1:0] {
        StEmpty   = 2'd0,
        StHalf    = 2'd1,
        StFull    = 2'd2,
        StIllegal = 2'd3
    } pipe_state_e;

    function automatic logic [1:0] fill_level(input logic valid_m, input logic valid_s);
        return {1'b0, valid_m} + {1'b0, valid_s};
    endfunction

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// One WIDTH-bit payload register with load enable and asynchronous reset to RESET_VAL.
module pipe_stage_reg_slot
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned          WIDTH     = PIPE_WIDTH,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data <= RESET_VAL;
        end else if (i_load) begin
            r_data <= i_data;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline-stage register with a 2-entry skid buffer and synchronous flush.
// Every output is driven straight from a flop, so out_ready never reaches in_ready combinationally.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned          WIDTH     = PIPE_WIDTH,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    logic        r_valid_m;
    logic        r_valid_s;
    logic [1:0]  r_occupancy;

    pipe_state_e w_state;
    logic        w_in_fire;
    logic        w_out_fire;
    logic        w_valid_m_d;
    logic        w_valid_s_d;
    logic        w_load_m;
    logic        w_load_s;
    logic        w_m_from_s;

    logic [WIDTH-1:0] w_data_m;
    logic [WIDTH-1:0] w_data_s;
    logic [WIDTH-1:0] w_data_m_next;

    assign w_in_fire  = in_valid & ~r_valid_s;
    assign w_out_fire = r_valid_m & out_ready;

    always_comb begin
        unique case ({r_valid_s, r_valid_m})
            2'b00:   w_state = StEmpty;
            2'b01:   w_state = StHalf;
            2'b11:   w_state = StFull;
            default: w_state = StIllegal;
        endcase
    end

    always_comb begin
        w_valid_m_d = r_valid_m;
        w_valid_s_d = r_valid_s;
        w_load_m    = 1'b0;
        w_load_s    = 1'b0;
        w_m_from_s  = 1'b0;
        if (flush) begin
            // Squash clears only the valid bits; payload registers keep their contents.
            w_valid_m_d = 1'b0;
            w_valid_s_d = 1'b0;
        end else begin
            unique case (w_state)
                StEmpty: begin
                    if (w_in_fire) begin
                        w_valid_m_d = 1'b1;
                        w_load_m    = 1'b1;
                    end
                end
                StHalf: begin
                    if (w_in_fire && w_out_fire) begin
                        w_load_m = 1'b1;
                    end else if (w_in_fire) begin
                        w_valid_s_d = 1'b1;
                        w_load_s    = 1'b1;
                    end else if (w_out_fire) begin
                        w_valid_m_d = 1'b0;
                    end
                end
                StFull: begin
                    if (w_out_fire) begin
                        w_valid_s_d = 1'b0;
                        w_load_m    = 1'b1;
                        w_m_from_s  = 1'b1;
                    end
                end
                default: begin
                    w_valid_m_d = 1'b0;
                    w_valid_s_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid_m   <= 1'b0;
            r_valid_s   <= 1'b0;
            r_occupancy <= 2'd0;
        end else begin
            r_valid_m   <= w_valid_m_d;
            r_valid_s   <= w_valid_s_d;
            r_occupancy <= fill_level(w_valid_m_d, w_valid_s_d);
        end
    end

    assign w_data_m_next = w_m_from_s ? w_data_s : in_data;

    pipe_stage_reg_slot #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_slot_m (
        .clk     (clk),
        .reset_n (reset_n),
        .i_load  (w_load_m),
        .i_data  (w_data_m_next),
        .o_data  (w_data_m)
    );

    pipe_stage_reg_slot #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_slot_s (
        .clk     (clk),
        .reset_n (reset_n),
        .i_load  (w_load_s),
        .i_data  (in_data),
        .o_data  (w_data_s)
    );

    assign out_data  = w_data_m;
    assign out_valid = r_valid_m;
    assign in_ready  = ~r_valid_s;
    assign occupancy = r_occupancy;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a queue model checked every cycle plus directed literal checks.
module tb_pipe_stage_reg;

    localparam int unsigned W   = 32;
    localparam logic [W-1:0] RST = 32'hDEAD_BEEF;

    logic         clk;
    logic         reset_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;

    int tests;
    int fails;

    logic [W-1:0] model_q[$];
    logic [W-1:0] model_last = RST;

    pipe_stage_reg #(
        .WIDTH     (W),
        .RESET_VAL (RST)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Reference: a FIFO of at most two words; out_data shows the head, or the last head once empty.
    initial begin
        bit can_push;
        bit can_pop;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                model_q.delete();
                model_last = RST;
            end else if (flush) begin
                if (model_q.size() != 0) model_last = model_q[0];
                model_q.delete();
            end else begin
                can_push = (model_q.size() < 2);
                can_pop  = (model_q.size() > 0);
                if (out_ready && can_pop) model_last = model_q.pop_front();
                if (in_valid && can_push) model_q.push_back(in_data);
            end
        end
    end

    initial begin
        logic [W-1:0] exp_data;
        forever begin
            @(negedge clk);
            exp_data = (model_q.size() != 0) ? model_q[0] : model_last;
            check("cyc_out_valid", 64'(out_valid), 64'(model_q.size() != 0));
            check("cyc_in_ready",  64'(in_ready),  64'(model_q.size() < 2));
            check("cyc_occupancy", 64'(occupancy), 64'(model_q.size()));
            check("cyc_out_data",  64'(out_data),  64'(exp_data));
        end
    end

    // Apply inputs just after a falling edge; they are sampled on the following rising edge.
    task automatic drive(input logic v, input logic [W-1:0] d, input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        @(negedge clk);
    endtask

    task automatic expect_out(input string name, input logic v, input logic rdy,
                              input logic [1:0] occ, input logic [W-1:0] d);
        check({name, "_valid"}, 64'(out_valid), 64'(v));
        check({name, "_ready"}, 64'(in_ready),  64'(rdy));
        check({name, "_occ"},   64'(occupancy), 64'(occ));
        check({name, "_data"},  64'(out_data),  64'(d));
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        @(negedge clk);
        @(negedge clk);
        expect_out("reset", 1'b0, 1'b1, 2'd0, 32'hDEAD_BEEF);
        reset_n = 1'b1;

        // Streaming at full rate: each word appears one cycle after acceptance.
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, W'(i), 1'b1, 1'b0);
            expect_out("stream", 1'b1, 1'b1, 2'd1, W'(i));
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        expect_out("drain", 1'b0, 1'b1, 2'd0, 32'h0000_0008);

        // Fill the skid slot, hold under stall, then drain.
        drive(1'b1, 32'hAAAA_0001, 1'b0, 1'b0);
        expect_out("fill1", 1'b1, 1'b1, 2'd1, 32'hAAAA_0001);
        drive(1'b1, 32'hAAAA_0002, 1'b0, 1'b0);
        expect_out("fill2", 1'b1, 1'b0, 2'd2, 32'hAAAA_0001);
        drive(1'b1, 32'hBBBB_BBBB, 1'b0, 1'b0);
        expect_out("stall", 1'b1, 1'b0, 2'd2, 32'hAAAA_0001);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        expect_out("pop1", 1'b1, 1'b1, 2'd1, 32'hAAAA_0002);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        expect_out("pop2", 1'b0, 1'b1, 2'd0, 32'hAAAA_0002);

        // Flush from FULL with a concurrent offer and pop.
        drive(1'b1, 32'hC0DE_0001, 1'b0, 1'b0);
        drive(1'b1, 32'hC0DE_0002, 1'b0, 1'b0);
        expect_out("prefl", 1'b1, 1'b0, 2'd2, 32'hC0DE_0001);
        drive(1'b1, 32'hC0DE_0003, 1'b1, 1'b1);
        expect_out("flush", 1'b0, 1'b1, 2'd0, 32'hC0DE_0001);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        expect_out("postfl", 1'b0, 1'b1, 2'd0, 32'hC0DE_0001);

        // Asynchronous reset while HALF, asserted away from the clock edge.
        drive(1'b1, 32'h1234_5678, 1'b0, 1'b0);
        expect_out("half", 1'b1, 1'b1, 2'd1, 32'h1234_5678);
        in_valid = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 expect_out("areset", 1'b0, 1'b1, 2'd0, 32'hDEAD_BEEF);
        @(negedge clk);
        reset_n = 1'b1;

        // Random traffic, occasionally flushed; the per-cycle checker does the work.
        for (int i = 0; i < 4000; i++) begin
            drive(1'($urandom_range(0, 3) != 0), W'($urandom), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 63) == 0));
        end
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 3) == 0), 1'b0);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);

        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
